// File: rtl/noaa_pkg.sv
// Shared widths, FSM state type and queued-entry layout for the NOAA report
// transmitter.
package noaa_pkg;

  localparam int unsigned RESULT_W     = 12;
  localparam int unsigned SEQ_W        = 3;
  localparam int unsigned FRAME_DATA_W = 16;
  localparam int unsigned FRAME_BITS   = 19;
  localparam int unsigned COUNT_W      = 5;
  localparam int unsigned BIT_CNT_W    = $clog2(FRAME_DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // One queued result; value sits in the low bits so it is sent first.
  typedef struct packed {
    logic [SEQ_W-1:0]    seq;
    logic                mode;
    logic [RESULT_W-1:0] value;
  } entry_t;

endpackage

// File: rtl/noaa_report_tx_if.sv
// Result-in / serial-report-out bundle of the NOAA report transmitter.
//   DONE, MODE, AVG_SD : result strobe, type tag and value from the averaging stage
//   TX, BUSY           : serial line (idle high) and frame-in-progress flag
//   OVERFLOW           : sticky dropped-result flag
//   FIFO_COUNT         : queued, unsent results
interface noaa_report_tx_if;
  import noaa_pkg::*;

  logic                DONE;
  logic                MODE;
  logic [RESULT_W-1:0] AVG_SD;
  logic                TX;
  logic                BUSY;
  logic                OVERFLOW;
  logic [COUNT_W-1:0]  FIFO_COUNT;

  modport master (
    output DONE, MODE, AVG_SD,
    input  TX, BUSY, OVERFLOW, FIFO_COUNT
  );

  modport slave (
    input  DONE, MODE, AVG_SD,
    output TX, BUSY, OVERFLOW, FIFO_COUNT
  );

endinterface

// File: rtl/noaa_report_fifo.sv
// Result FIFO for the report transmitter (power-of-two depth).
//   CLK, RESET_N : clock, async active-low reset (pointers and count only)
//   push, wdata  : write request and data; taken when not full or when popping
//   pop, rdata_c : read request and head-of-queue data (combinational)
//   count        : registered occupancy
//   full_c, empty_c : occupancy flags derived from count
module noaa_report_fifo
  import noaa_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = FRAME_DATA_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata_c,
  output logic [COUNT_W-1:0] count,
  output logic               full_c,
  output logic               empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en_c;
  logic              rd_en_c;

  assign full_c  = (count == COUNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign rd_en_c = pop & ~empty_c;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_en_c = push & (~full_c | rd_en_c);
  assign rdata_c = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en_c, rd_en_c})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge CLK) begin
    if (wr_en_c) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/noaa_report_tx.sv
// NOAA report transmitter: queues averaging/SD results on DONE rising edges and
// sends each as a 19-bit serial frame (start, 16 data LSB first, even parity, stop).
//   CLK, RESET_N : clock, async active-low reset
//   bus (slave)  : DONE/MODE/AVG_SD in; TX/BUSY/OVERFLOW/FIFO_COUNT out (all registered)
module noaa_report_tx
  import noaa_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BAUD_DIV   = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  noaa_report_tx_if.slave  bus
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_DATA_W - 1);

  logic                    done_q;
  logic [SEQ_W-1:0]        seq_q;
  logic                    overflow_q;
  logic                    capture_c;
  logic                    accept_c;
  logic                    pop_c;
  entry_t                  push_entry_c;
  logic [FRAME_DATA_W-1:0] fifo_rdata_c;
  logic [COUNT_W-1:0]      fifo_count;
  logic                    fifo_full_c;
  logic                    fifo_empty_c;

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_CNT_W-1:0]    bit_q, bit_d;
  logic [FRAME_DATA_W-1:0] shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;

  // Rising-edge capture and FIFO accept decision.
  assign capture_c    = bus.DONE & ~done_q;
  assign accept_c     = capture_c & (~fifo_full_c | pop_c);
  assign push_entry_c = '{seq: seq_q, mode: bus.MODE, value: bus.AVG_SD};

  noaa_report_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (FRAME_DATA_W)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (capture_c),
    .pop     (pop_c),
    .wdata   (push_entry_c),
    .rdata_c (fifo_rdata_c),
    .count   (fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // DONE history, sequence number and sticky overflow.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      done_q     <= 1'b0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= bus.DONE;
      if (accept_c)               seq_q      <= seq_q + SEQ_W'(1);
      if (capture_c && !accept_c) overflow_q <= 1'b1;
    end
  end

  // Frame FSM and serializer registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  // Next state; TX/BUSY are decoded from the next state so they register in step.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop_c    = 1'b0;
    tx_d     = 1'b1;
    busy_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_c) begin
          pop_c    = 1'b1;
          shift_d  = fifo_rdata_c;
          parity_d = ^fifo_rdata_c;
          bit_d    = '0;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + BIT_CNT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  begin tx_d = 1'b0;       busy_d = 1'b1; end
      ST_DATA:   begin tx_d = shift_d[0]; busy_d = 1'b1; end
      ST_PARITY: begin tx_d = parity_d;   busy_d = 1'b1; end
      ST_STOP:   begin tx_d = 1'b1;       busy_d = 1'b1; end
      default:   begin tx_d = 1'b1;       busy_d = 1'b0; end
    endcase
  end

  assign bus.TX         = tx_q;
  assign bus.BUSY       = busy_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.FIFO_COUNT = fifo_count;

endmodule
